md_unit: RTL and testbench
==========================

# md_unit

Multiply/divide unit for the pipelined MIPS core's execute stage, directly downstream of the instruction decoder. It consumes the decoder's one-hot `mult/multu/div/divu/mthi/mtlo/mfhi/mflo` strobes together with the forwarded rs/rt operands, and owns the HI/LO registers. It models fixed multi-cycle latency and exports busy information so the hazard unit can stall later HI/LO users.

## Interface
- `MULT_CYCLES`, default 5, busy cycles for `mult`/`multu`.
- `DIV_CYCLES`, default 10, busy cycles for `div`/`divu`.

Ports:
- `clk`, input, 1, sole clock; all state updates on the rising edge.
- `rst_n`, input, 1, asynchronous, active-low reset.
- `en`, input, 1, the E-stage instruction is valid and not cancelled by an exception or flush. When low, every op strobe is ignored.
- `mult`, `multu`, `div`, `divu`, `mthi`, `mtlo`, `mfhi`, `mflo`, input, 1 each, decoder strobes for the E-stage instruction. At most one is high.
- `a`, input, 32, rs operand after forwarding.
- `b`, input, 32, rt operand after forwarding.
- `start`, output, 1, combinational: a mul/div is issued this cycle.
- `busy`, output, 1, registered: a mul/div is in flight.
- `hilo_hazard`, output, 1, combinational: `start | busy`. The hazard unit stalls any D-stage HI/LO-touching instruction while this is high.
- `hi`, output, 32, HI register.
- `lo`, output, 32, LO register.
- `rd_data`, output, 32, combinational: `hi` when `mfhi`, `lo` when `mflo`, else 0.

## Operation
- States: `IDLE`, `MUL`, `DIV`. A down-counter `cnt` is 4 bits (sized to the larger of the two parameters).
- Issue: `start = en & (mult|multu|div|divu) & (state==IDLE)`. On the issue edge:
  - Latch the result into pending registers `p_hi` and `p_lo`.
  - Load `cnt` with `MULT_CYCLES-1` or `DIV_CYCLES-1`.
  - Go to `MUL` or `DIV`.
- `mult`: the signed 64-bit product of `a` and `b` gives `{p_hi,p_lo}`.
- `multu`: the same, unsigned.
- `div` (signed):
  - `p_lo` = quotient, truncated toward zero.
  - `p_hi` = remainder, with the sign of the dividend.
  - `0x80000000 / 0xFFFFFFFF` gives LO=`0x80000000`, HI=0.
- `divu`: unsigned quotient/remainder.
- Divide by zero (`b==0`, `div` or `divu`):
  - The busy sequence runs normally.
  - HI/LO are left unchanged at commit.
  - The no-write decision is captured at issue.
- In `MUL`/`DIV`:
  - `cnt` decrements each cycle.
  - When `cnt==0`, `hi<=p_hi`, `lo<=p_lo`, and the state returns to `IDLE` on the same edge.
- `busy = (state != IDLE)`.
- `mthi`/`mtlo`:
  - With `en` high and state `IDLE`, write `a` into HI/LO on the next edge.
  - While busy they are ignored. This case is unreachable under correct stalling and is a protocol violation.
- A mul/div strobe while busy is ignored. This is a protocol violation; the hazard unit prevents it.
- `mfhi`/`mflo` read the current committed registers. The pending result is not forwarded.
- Flush/exception after issue does not cancel the in-flight operation. The precise-exception policy gates `en` at issue only.
- Reset (any time, including mid-operation):
  - State goes to `IDLE`, `cnt` to 0.
  - `hi`, `lo`, `p_hi`, `p_lo` go to 0.
  - `busy` goes to 0 immediately; the pending result is discarded.

## Timing
- Issue in cycle T: `start`=1 in T, and `busy`=1 from T+1.
- Mult: `busy` is high for T+1..T+5. HI/LO are updated at the edge ending T+5, and `busy`=0 in T+6.
- Div: `busy` is high for T+1..T+10. HI/LO are updated at the edge ending T+10, and `busy`=0 in T+11.
- A new mul/div may issue in the first cycle `busy` is 0 (T+6 for mult, T+11 for div). Back-to-back operations have no bubble beyond that.
- `mthi`/`mtlo` take effect one edge after they are presented. The next-cycle `hi`/`lo` show the new value.
- `rd_data` is zero-latency from the registers.
- Reset reaches outputs asynchronously, without waiting for a clock.

## Test plan
- `mult` with a=`0xFFFFFFFE` (-2), b=3:
  - `start` is high for 1 cycle, then `busy` is high for exactly 5 cycles.
  - Afterwards hi=`0xFFFFFFFF`, lo=`0xFFFFFFFA`.
  - The same operands with `multu` give hi=2, lo=`0xFFFFFFFA`.
- `div` with a=-7, b=2 gives lo=`0xFFFFFFFD`, hi=`0xFFFFFFFF` after 10 busy cycles. `divu` with a=7, b=2 gives lo=3, hi=1.
- Divide by zero:
  - Preload with `mthi 0x11`, `mtlo 0x22`, then issue `div` with b=0.
  - `busy` is high for 10 cycles, and afterwards hi=0x11, lo=0x22.
  - Overflow case: `0x80000000/-1` gives lo=`0x80000000`, hi=0.
- `hilo_hazard` and ignored strobes:
  - `hilo_hazard` is high from the issue cycle through the last busy cycle.
  - A `mflo` presented while busy returns the old `lo`.
  - A second `mult` strobe while busy does not restart the counter.
  - With `en`=0, a `mult` strobe produces no `start`.
- Deassert `rst_n` in the 3rd busy cycle of a `div`: `busy`, `hi`, `lo` are 0 immediately, and no later commit occurs after reset is released.
- `mtlo` with a=`0xDEADBEEF` while idle gives lo=`0xDEADBEEF` next cycle, and `mflo` then gives rd_data=`0xDEADBEEF`.

Source files
------------

// File: rtl/md_unit.sv
// Multiply/divide unit for the E stage: owns HI/LO, models fixed mul/div latency,
// and exports busy/hazard information for the hazard unit.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        mult,
    input  logic        multu,
    input  logic        div,
    input  logic        divu,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic        mfhi,
    input  logic        mflo,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        start,
    output logic        busy,
    output logic        hilo_hazard,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [31:0]      r_p_hi;
    logic [31:0]      r_p_lo;
    logic             r_wr;

    logic        w_idle;
    logic        w_is_mul;
    logic        w_is_div;
    logic [63:0] w_a_ext;
    logic [63:0] w_b_ext;
    logic [63:0] w_prod;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_b_safe;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    assign w_idle      = (r_state == IDLE);
    assign w_is_mul    = mult | multu;
    assign w_is_div    = div | divu;
    assign start       = en & (w_is_mul | w_is_div) & w_idle;
    assign busy        = !w_idle;
    assign hilo_hazard = start | busy;
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign rd_data     = mfhi ? r_hi : (mflo ? r_lo : 32'd0);

    // One 64x64 multiplier serves both flavours; only the extension differs.
    assign w_a_ext = {{32{mult & a[31]}}, a};
    assign w_b_ext = {{32{mult & b[31]}}, b};
    assign w_prod  = w_a_ext * w_b_ext;

    // Signed divide on magnitudes: avoids the INT_MIN / -1 overflow trap and
    // gives truncation toward zero with the remainder taking the dividend's sign.
    assign w_a_neg  = div & a[31];
    assign w_b_neg  = div & b[31];
    assign w_a_mag  = w_a_neg ? -a : a;
    assign w_b_mag  = w_b_neg ? -b : b;
    assign w_b_safe = (b == 32'd0) ? 32'd1 : w_b_mag;
    assign w_q_mag  = w_a_mag / w_b_safe;
    assign w_r_mag  = w_a_mag % w_b_safe;
    assign w_quot   = (w_a_neg ^ w_b_neg) ? -w_q_mag : w_q_mag;
    assign w_rem    = w_a_neg ? -w_r_mag : w_r_mag;

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; the pending result is reset too so an aborted op leaves nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_p_hi  <= 32'd0;
            r_p_lo  <= 32'd0;
            r_wr    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_p_hi  <= w_is_mul ? w_prod[63:32] : w_rem;
                        r_p_lo  <= w_is_mul ? w_prod[31:0]  : w_quot;
                        r_wr    <= w_is_mul | (b != 32'd0);
                        r_cnt   <= w_is_mul ? MULT_LOAD : DIV_LOAD;
                        r_state <= w_is_mul ? MUL : DIV;
                    end else if (en && mthi) begin
                        r_hi <= a;
                    end else if (en && mtlo) begin
                        r_lo <= a;
                    end
                end
                default: begin
                    if (r_cnt == '0) begin
                        if (r_wr) begin
                            r_hi <= r_p_hi;
                            r_lo <= r_p_lo;
                        end
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: stimulus pushes expected HI/LO, a monitor
// pops and compares whenever a mul/div completes (busy falls).
module tb_md_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [7:0]  strb;  // {mult,multu,div,divu,mthi,mtlo,mfhi,mflo}
    logic [31:0] a, b;
    logic        start, busy, hilo_hazard;
    logic [31:0] hi, lo, rd_data;

    localparam logic [7:0] OP_MULT  = 8'h80;
    localparam logic [7:0] OP_MULTU = 8'h40;
    localparam logic [7:0] OP_DIV   = 8'h20;
    localparam logic [7:0] OP_DIVU  = 8'h10;
    localparam logic [7:0] OP_MTHI  = 8'h08;
    localparam logic [7:0] OP_MTLO  = 8'h04;
    localparam logic [7:0] OP_MFHI  = 8'h02;
    localparam logic [7:0] OP_MFLO  = 8'h01;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    md_unit dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .mult(strb[7]), .multu(strb[6]), .div(strb[5]), .divu(strb[4]),
        .mthi(strb[3]), .mtlo(strb[2]), .mfhi(strb[1]), .mflo(strb[0]),
        .a(a), .b(b), .start(start), .busy(busy), .hilo_hazard(hilo_hazard),
        .hi(hi), .lo(lo), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a falling busy outside reset is a commit.
    logic prev_busy = 1'b0;
    always @(negedge clk) begin
        if (prev_busy && !busy && rst_n) begin
            if (sb_q.size() == 0) begin
                check("unexpected_commit", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("commit_hi", hi, e.hi);
                check("commit_lo", lo, e.lo);
            end
        end
        prev_busy = busy;
    end

    // Issue one mul/div, check the start pulse, busy length and hazard coverage.
    task automatic run_op(input string name, input logic [7:0] op, input logic [31:0] aa,
                          input logic [31:0] bb, input logic [31:0] ehi, input logic [31:0] elo,
                          input int cycles);
        int n_busy = 0;
        int hz_bad = 0;
        exp_t e;
        @(posedge clk); #1;
        strb = op; a = aa; b = bb;
        @(negedge clk);
        check({name, "_start"}, 32'(start), 32'd1);
        check({name, "_hazard_issue"}, 32'(hilo_hazard), 32'd1);
        e.hi = ehi; e.lo = elo;
        sb_q.push_back(e);
        @(posedge clk); #1;
        strb = 8'h00;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!busy) break;
            n_busy++;
            if (!hilo_hazard || start) hz_bad++;
        end
        check({name, "_busy_len"}, 32'(n_busy), 32'(cycles));
        check({name, "_hazard_busy"}, 32'(hz_bad), 32'd0);
    endtask

    task automatic write_hilo(input logic [7:0] op, input logic [31:0] val);
        @(posedge clk); #1;
        strb = op; a = val;
        @(posedge clk); #1;
        strb = 8'h00;
    endtask

    initial begin
        int n_busy;
        int bad;
        rst_n = 1'b0; en = 1'b1; strb = 8'h00; a = 32'd0; b = 32'd0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_start", 32'(start), 32'd0);
        check("rst_rd_data", rd_data, 32'd0);

        run_op("mult",  OP_MULT,  32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
        run_op("multu", OP_MULTU, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, 5);
        run_op("div",   OP_DIV,   32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        run_op("divu",  OP_DIVU,  32'd7,        32'd2, 32'd1,        32'd3,        10);

        write_hilo(OP_MTHI, 32'h11);
        check("mthi", hi, 32'h11);
        write_hilo(OP_MTLO, 32'h22);
        check("mtlo", lo, 32'h22);
        run_op("div0", OP_DIV, 32'd1234, 32'd0, 32'h11, 32'h22, 10);
        run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 10);

        // en low: strobe must not issue.
        @(posedge clk); #1;
        en = 1'b0; strb = OP_MULT; a = 32'd9; b = 32'd9;
        @(negedge clk);
        check("en0_start", 32'(start), 32'd0);
        check("en0_hazard", 32'(hilo_hazard), 32'd0);
        @(posedge clk); #1;
        en = 1'b1; strb = 8'h00;
        @(negedge clk);
        check("en0_busy", 32'(busy), 32'd0);

        // mflo while busy reads old lo; a second mult while busy is ignored.
        @(posedge clk); #1;
        strb = OP_MULT; a = 32'd5; b = 32'd7;
        @(negedge clk);
        check("ign_start", 32'(start), 32'd1);
        sb_q.push_back('{hi: 32'd0, lo: 32'h23});
        @(posedge clk); #1;
        strb = OP_MFLO;
        @(negedge clk);
        check("ign_mflo_busy", rd_data, 32'h80000000);
        @(posedge clk); #1;
        strb = OP_MULT; a = 32'd1; b = 32'd1;
        @(negedge clk);
        check("ign_second_start", 32'(start), 32'd0);
        @(posedge clk); #1;
        strb = 8'h00;
        n_busy = 2;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!busy) break;
            n_busy++;
        end
        check("ign_busy_len", 32'(n_busy), 32'd5);

        // Reset in the 3rd busy cycle of a div.
        @(posedge clk); #1;
        strb = OP_DIVU; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        strb = 8'h00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_busy_before_rst", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_hi", hi, 32'd0);
        check("mid_rst_lo", lo, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (busy || hi != 32'd0 || lo != 32'd0) bad++;
        end
        check("mid_rst_no_commit", 32'(bad), 32'd0);

        write_hilo(OP_MTLO, 32'hDEADBEEF);
        check("mtlo_dead", lo, 32'hDEADBEEF);
        strb = OP_MFLO;
        #1;
        check("mflo_dead", rd_data, 32'hDEADBEEF);
        strb = OP_MFHI;
        #1;
        check("mfhi_zero", rd_data, 32'd0);
        strb = 8'h00;

        repeat (2) @(negedge clk);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
